// File: rtl/display_bcm_sequencer_pkg.sv
// Shared types and width helpers for the BCM row sequencer.
package display_bcm_sequencer_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StLatch,
        StBlank,
        StOn
    } state_e;

    // Width of a plane index; a single-plane design still needs one bit.
    function automatic int unsigned sel_width(input int unsigned bitwidth);
        return (bitwidth > 1) ? $clog2(bitwidth) : 1;
    endfunction

    // Width of the period counter, period length and on-length registers.
    function automatic int unsigned cnt_width(input int unsigned bitwidth,
                                              input int unsigned base_ticks);
        return bitwidth + $clog2(base_ticks + 1);
    endfunction

endpackage

// File: rtl/display_bcm_plane_timer.sv
// Period timer for one bit plane: holds the period length and the lit length,
// counts the ON cycles and flags the last cycle of the period.
module display_bcm_plane_timer
    import display_bcm_sequencer_pkg::*;
#(
    parameter int unsigned BITWIDTH   = 8,
    parameter int unsigned BASE_TICKS = 1,
    parameter int unsigned BRIGHT_W   = 4,
    parameter int unsigned SEL_W      = sel_width(BITWIDTH),
    parameter int unsigned CNT_W      = cnt_width(BITWIDTH, BASE_TICKS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                run,
    input  logic [SEL_W-1:0]    plane,
    input  logic [BRIGHT_W-1:0] brightness,
    output logic                oe_raw,
    output logic                period_end
);

    localparam int unsigned PROD_W = CNT_W + BRIGHT_W;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  w_q, w_d;
    logic [CNT_W-1:0]  on_len_q, on_len_d;
    logic [PROD_W-1:0] prod;

    // Next-state: load a new plane (counter back to 0) or advance while lit.
    always_comb begin
        w_d      = w_q;
        on_len_d = on_len_q;
        cnt_d    = cnt_q;
        prod     = '0;
        if (load) begin
            w_d      = CNT_W'(BASE_TICKS) << plane;
            prod     = PROD_W'(w_d) * (PROD_W'(brightness) + PROD_W'(1));
            on_len_d = CNT_W'(prod >> BRIGHT_W);
            cnt_d    = '0;
        end else if (run) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // oe_raw looks one cycle ahead so the sequencer can register oe;
    // period_end refers to the current counter value.
    assign oe_raw     = (cnt_d < on_len_d);
    assign period_end = (cnt_q == w_q - CNT_W'(1));

    // Timer state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            w_q      <= '0;
            on_len_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            w_q      <= w_d;
            on_len_q <= on_len_d;
        end
    end

endmodule

// File: rtl/display_bcm_sequencer.sv
// Binary-code-modulation row sequencer: walks planes MSB-first, requests each
// plane from the column shifter, latches it, blanks, then lights it for a
// brightness-scaled part of its binary-weighted period while prefetching the next.
module display_bcm_sequencer
    import display_bcm_sequencer_pkg::*;
#(
    parameter int unsigned BITWIDTH     = 8,
    parameter int unsigned BASE_TICKS   = 1,
    parameter int unsigned BLANK_CYCLES = 2,
    parameter int unsigned BRIGHT_W     = 4,
    localparam int unsigned SEL_W       = sel_width(BITWIDTH),
    localparam int unsigned CNT_W       = cnt_width(BITWIDTH, BASE_TICKS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [BRIGHT_W-1:0] brightness,
    output logic                busy,
    output logic                plane_req,
    output logic [SEL_W-1:0]    req_plane,
    input  logic                plane_ack,
    output logic                latch,
    output logic [SEL_W-1:0]    select,
    output logic                oe,
    output logic                row_done
);

    localparam int unsigned BLK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

    state_e              state_q, state_d;
    logic [SEL_W-1:0]    plane_q, plane_d;
    logic [BRIGHT_W-1:0] bright_q, bright_d;
    logic [BLK_W-1:0]    blank_q, blank_d;
    logic                pf_q, pf_d;
    logic                busy_q, busy_d;
    logic                plane_req_q, plane_req_d;
    logic [SEL_W-1:0]    req_plane_q, req_plane_d;
    logic                latch_q, latch_d;
    logic [SEL_W-1:0]    select_q, select_d;
    logic                oe_q, oe_d;
    logic                row_done_q, row_done_d;

    logic ack;
    logic oe_raw;
    logic period_end;

    assign ack = plane_req_q && plane_ack;

    display_bcm_plane_timer #(
        .BITWIDTH  (BITWIDTH),
        .BASE_TICKS(BASE_TICKS),
        .BRIGHT_W  (BRIGHT_W),
        .SEL_W     (SEL_W),
        .CNT_W     (CNT_W)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (state_q == StLatch),
        .run       (state_q == StOn),
        .plane     (plane_q),
        .brightness(bright_q),
        .oe_raw    (oe_raw),
        .period_end(period_end)
    );

    // Next state and next registered outputs; outputs follow the state entered.
    always_comb begin
        state_d     = state_q;
        plane_d     = plane_q;
        bright_d    = bright_q;
        blank_d     = blank_q;
        pf_d        = pf_q;
        busy_d      = busy_q;
        plane_req_d = 1'b0;
        req_plane_d = req_plane_q;
        latch_d     = 1'b0;
        select_d    = select_q;
        row_done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                busy_d = 1'b0;
                if (start) begin
                    bright_d    = brightness;
                    plane_d     = SEL_W'(BITWIDTH - 1);
                    state_d     = StReq;
                    busy_d      = 1'b1;
                    plane_req_d = 1'b1;
                    req_plane_d = SEL_W'(BITWIDTH - 1);
                end
            end
            StReq: begin
                if (ack) begin
                    state_d  = StLatch;
                    latch_d  = 1'b1;
                    select_d = plane_q;
                end else begin
                    plane_req_d = 1'b1;
                end
            end
            StLatch: begin
                pf_d    = 1'b0;
                blank_d = '0;
                state_d = (BLANK_CYCLES > 0) ? StBlank : StOn;
            end
            StBlank: begin
                if (blank_q == BLK_W'(BLANK_CYCLES - 1)) begin
                    state_d = StOn;
                end else begin
                    blank_d = blank_q + BLK_W'(1);
                end
            end
            StOn: begin
                // Prefetch request stays up until the shifter takes it.
                if (plane_req_q && !plane_ack) begin
                    plane_req_d = 1'b1;
                end
                if (ack) begin
                    pf_d = 1'b1;
                end
                if (period_end) begin
                    if (plane_q == '0) begin
                        state_d     = StIdle;
                        row_done_d  = 1'b1;
                        busy_d      = 1'b0;
                        plane_req_d = 1'b0;
                    end else if (pf_q || ack) begin
                        plane_d     = plane_q - SEL_W'(1);
                        state_d     = StLatch;
                        latch_d     = 1'b1;
                        select_d    = plane_q - SEL_W'(1);
                        pf_d        = 1'b0;
                        plane_req_d = 1'b0;
                    end else begin
                        // Shifter not ready: wait in REQ with the same request held.
                        plane_d     = plane_q - SEL_W'(1);
                        state_d     = StReq;
                        plane_req_d = 1'b1;
                        req_plane_d = plane_q - SEL_W'(1);
                    end
                end
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase

        // Entering ON: raise the prefetch for the next lower plane.
        if (state_d == StOn && state_q != StOn && plane_q != '0) begin
            plane_req_d = 1'b1;
            req_plane_d = plane_q - SEL_W'(1);
        end

        if (abort) begin
            state_d     = StIdle;
            busy_d      = 1'b0;
            pf_d        = 1'b0;
            plane_req_d = 1'b0;
            latch_d     = 1'b0;
            row_done_d  = 1'b0;
            select_d    = select_q;
        end

        oe_d = (state_d == StOn) && oe_raw;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            plane_q     <= '0;
            bright_q    <= '0;
            blank_q     <= '0;
            pf_q        <= 1'b0;
            busy_q      <= 1'b0;
            plane_req_q <= 1'b0;
            req_plane_q <= '0;
            latch_q     <= 1'b0;
            select_q    <= '0;
            oe_q        <= 1'b0;
            row_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            plane_q     <= plane_d;
            bright_q    <= bright_d;
            blank_q     <= blank_d;
            pf_q        <= pf_d;
            busy_q      <= busy_d;
            plane_req_q <= plane_req_d;
            req_plane_q <= req_plane_d;
            latch_q     <= latch_d;
            select_q    <= select_d;
            oe_q        <= oe_d;
            row_done_q  <= row_done_d;
        end
    end

    assign busy      = busy_q;
    assign plane_req = plane_req_q;
    assign req_plane = req_plane_q;
    assign latch     = latch_q;
    assign select    = select_q;
    assign oe        = oe_q;
    assign row_done  = row_done_q;

endmodule

// File: tb/tb_display_bcm_sequencer.sv
// Bench for the BCM row sequencer: a timeline model builds the expected
// per-cycle outputs of each row from the plane rules, and one negedge
// process compares the DUT against it; literal counts pin the model.
module tb_display_bcm_sequencer;

    localparam int unsigned BITWIDTH     = 4;
    localparam int unsigned BASE_TICKS   = 2;
    localparam int unsigned BLANK_CYCLES = 1;
    localparam int unsigned BRIGHT_W     = 4;
    localparam int          MAXC         = 128;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic                abort;
    logic [BRIGHT_W-1:0] brightness;
    logic                busy;
    logic                plane_req;
    logic [1:0]          req_plane;
    logic                plane_ack;
    logic                latch;
    logic [1:0]          select;
    logic                oe;
    logic                row_done;

    display_bcm_sequencer #(
        .BITWIDTH    (BITWIDTH),
        .BASE_TICKS  (BASE_TICKS),
        .BLANK_CYCLES(BLANK_CYCLES),
        .BRIGHT_W    (BRIGHT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .brightness(brightness),
        .busy      (busy),
        .plane_req (plane_req),
        .req_plane (req_plane),
        .plane_ack (plane_ack),
        .latch     (latch),
        .select    (select),
        .oe        (oe),
        .row_done  (row_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    // Expected timeline of one row, indexed by cycle relative to the start cycle.
    bit e_busy [MAXC];
    bit e_req  [MAXC];
    int e_rp   [MAXC];
    bit e_latch[MAXC];
    int e_sel  [MAXC];
    bit e_oe   [MAXC];
    bit e_rd   [MAXC];

    int exp_base = 0;
    bit model_en = 1'b0;
    int m_select = 0;
    int ack_a    = 0;
    int ack_b    = 0;

    // Per-row observations of the DUT.
    int oe_cnt[4];
    int latch_cnt;
    int rd_cnt;
    int first_sel;
    int req2_cnt;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    function automatic bit ackv(input int k);
        return !(k >= ack_a && k < ack_b);
    endfunction

    function automatic int outs();
        return int'({busy, plane_req, req_plane, latch, select, oe, row_done});
    endfunction

    // Row timeline: each plane is requested until the first acked cycle, latched
    // one cycle after max(previous period end, ack), blanked, then lit for
    // (W*(b+1))>>BRIGHT_W of its W = BASE_TICKS<<p cycles.
    task automatic build_model(input int b, input int abort_at);
        int rs, d, lat, on0, w, onl, prev_end;
        for (int k = 0; k < MAXC; k++) begin
            e_busy[k] = 0; e_req[k] = 0; e_rp[k] = 0; e_latch[k] = 0;
            e_sel[k] = m_select; e_oe[k] = 0; e_rd[k] = 0;
        end
        prev_end = 0;
        rs = 1;
        for (int p = BITWIDTH - 1; p >= 0; p--) begin
            d = rs;
            while (d < MAXC - 1 && !ackv(d)) d++;
            for (int k = rs; k <= d; k++) begin
                e_req[k] = 1; e_rp[k] = p;
            end
            lat = ((prev_end > d) ? prev_end : d) + 1;
            e_latch[lat] = 1;
            for (int k = lat; k < MAXC; k++) e_sel[k] = p;
            on0 = lat + 1 + BLANK_CYCLES;
            w   = BASE_TICKS << p;
            onl = (w * (b + 1)) >> BRIGHT_W;
            for (int j = 0; j < w; j++) e_oe[on0 + j] = (j < onl);
            prev_end = on0 + w - 1;
            rs = on0;
        end
        e_rd[prev_end + 1] = 1;
        for (int k = 1; k <= prev_end; k++) e_busy[k] = 1;
        if (abort_at >= 0) begin
            for (int k = abort_at + 1; k < MAXC; k++) begin
                e_busy[k] = 0; e_req[k] = 0; e_latch[k] = 0; e_oe[k] = 0; e_rd[k] = 0;
                e_sel[k] = e_sel[abort_at];
            end
        end
    endtask

    // Per-cycle comparison against the model, plus observation counters.
    always @(negedge clk) begin
        int k;
        logic [8:0] ev;
        logic [8:0] av;
        if (model_en) begin
            k = cyc - exp_base;
            if (k == 0) begin
                for (int i = 0; i < 4; i++) oe_cnt[i] = 0;
                latch_cnt = 0; rd_cnt = 0; first_sel = -1; req2_cnt = 0;
            end
            if (k >= 0 && k < MAXC) begin
                ev = {e_busy[k], e_req[k], e_req[k] ? 2'(e_rp[k]) : 2'b00, e_latch[k],
                      2'(e_sel[k]), e_oe[k], e_rd[k]};
                av = {busy, plane_req, plane_req ? req_plane : 2'b00, latch, select, oe, row_done};
                chk($sformatf("cycle%0d {busy,req,rp,latch,sel,oe,done}", k), int'(av), int'(ev));
            end
            if (oe) oe_cnt[select]++;
            if (latch) begin
                if (latch_cnt == 0) first_sel = int'(select);
                latch_cnt++;
            end
            if (row_done) rd_cnt++;
            if (plane_req && req_plane == 2'd2) req2_cnt++;
        end
    end

    task automatic run_row(input int b, input int b_late, input int abort_at,
                           input int start_again, input int ncyc);
        @(posedge clk); #1;
        exp_base = cyc;
        build_model(b, abort_at);
        start = 1'b1; abort = 1'b0; brightness = 4'(b); plane_ack = ackv(0);
        model_en = 1'b1;
        for (int k = 1; k < ncyc; k++) begin
            @(posedge clk); #1;
            start     = (k == start_again);
            abort     = (k == abort_at);
            plane_ack = ackv(k);
            if (k == 5) brightness = 4'(b_late);
        end
        @(posedge clk); #1;
        model_en = 1'b0; start = 1'b0; abort = 1'b0;
        m_select = e_sel[ncyc - 1];
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; abort = 1'b0; plane_ack = 1'b0; brightness = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset outputs", outs(), 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // T1: full brightness, ack always ready.
        run_row(15, 15, -1, -1, 44);
        chk("T1 oe plane3", oe_cnt[3], 16);
        chk("T1 oe plane2", oe_cnt[2], 8);
        chk("T1 oe plane1", oe_cnt[1], 4);
        chk("T1 oe plane0", oe_cnt[0], 2);
        chk("T1 latches", latch_cnt, 4);
        chk("T1 first select", first_sel, 3);
        chk("T1 row_done", rd_cnt, 1);
        chk("T1 busy idle", int'(busy), 0);

        // T2: half brightness; a brightness change mid-row must be ignored.
        run_row(7, 0, -1, -1, 44);
        chk("T2 oe plane3", oe_cnt[3], 8);
        chk("T2 oe plane2", oe_cnt[2], 4);
        chk("T2 oe plane1", oe_cnt[1], 2);
        chk("T2 oe plane0", oe_cnt[0], 1);

        // T4: plane-2 prefetch ack withheld until 5 cycles after plane 3 ends.
        ack_a = 4; ack_b = 24;
        run_row(15, 15, -1, -1, 50);
        ack_a = 0; ack_b = 0;
        chk("T4 req plane2 cycles", req2_cnt, 21);
        chk("T4 latches", latch_cnt, 4);
        chk("T4 oe plane2", oe_cnt[2], 8);

        // T5: abort in the 3rd ON cycle of plane 1.
        run_row(15, 15, 34, -1, 40);
        chk("T5 row_done", rd_cnt, 0);
        chk("T5 latches", latch_cnt, 3);
        chk("T5 select held", int'(select), 1);

        // T5b/T6: restart after abort, with a start pulse while busy.
        run_row(3, 3, -1, 10, 44);
        chk("T5b first select", first_sel, 3);
        chk("T5b oe plane3", oe_cnt[3], 4);
        chk("T5b oe plane0", oe_cnt[0], 0);
        chk("T5b row_done", rd_cnt, 1);

        // T6: asynchronous reset in the middle of plane 3 ON.
        @(posedge clk); #1;
        start = 1'b1; brightness = 4'd15; plane_ack = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        chk("T6 oe before reset", int'(oe), 1);
        rst = 1'b0;
        #1;
        chk("T6 outputs in reset", outs(), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        m_select = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("T6 idle after reset %0d", i), outs(), 0);
        end

        // T3: zero brightness lights plane 3 for one cycle only.
        run_row(0, 0, -1, -1, 44);
        chk("T3 oe plane3", oe_cnt[3], 1);
        chk("T3 oe lower planes", oe_cnt[2] + oe_cnt[1] + oe_cnt[0], 0);
        chk("T3 row_done", rd_cnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
